// File: rtl/arb_pkg.sv
// Shared constants, types and helpers for the stream arbiter/mux slice.
package arb_pkg;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_e;

    // Channel index width; a single channel still needs a 1-bit select.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        int unsigned w;
        w = (n <= 1) ? 1 : int'($clog2(n));
        return w;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin / fixed-priority picker using a double-width masked priority encode.
module arb_rr_pick #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    input  logic              mode,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              any_req
);

    logic [NUM_CH-1:0]   mask;
    logic [2*NUM_CH-1:0] dbl;
    logic                found;

    always_comb begin
        mask      = '0;
        dbl       = '0;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        // Fixed priority is round-robin with the search origin pinned at 0.
        for (int i = 0; i < int'(NUM_CH); i++) begin
            mask[i] = mode || (i >= int'(ptr));
        end
        dbl = {req, req & mask};
        for (int i = 0; i < 2 * int'(NUM_CH); i++) begin
            if (!found && dbl[i]) begin
                found = 1'b1;
                if (i >= int'(NUM_CH)) begin
                    grant[i - int'(NUM_CH)] = 1'b1;
                    grant_idx               = IDX_W'(i - int'(NUM_CH));
                end else begin
                    grant[i]  = 1'b1;
                    grant_idx = IDX_W'(i);
                end
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/stream_arb_mux.sv
// N-way valid/ready stream arbiter with a single registered output stage and optional packet lock.
module stream_arb_mux
    import arb_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned ARB_MODE = ARB_RR,
    parameter int unsigned PKT_MODE = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             in_valid,
    output logic [NUM_CH-1:0]             in_ready,
    input  logic [NUM_CH*DATA_W-1:0]      in_data,
    input  logic [NUM_CH-1:0]             in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_last,
    output logic [ch_idx_w(NUM_CH)-1:0]   out_sel
);

    localparam int unsigned IDX_W = ch_idx_w(NUM_CH);

    lock_e             lock_q, lock_d;
    logic [IDX_W-1:0]  lock_ch_q, lock_ch_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [NUM_CH-1:0] lock_mask, req, grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              any_req, load, xfer, sel_last, beat_last;
    logic [DATA_W-1:0] sel_data;

    logic              out_valid_q, out_last_q;
    logic [DATA_W-1:0] out_data_q;
    logic [IDX_W-1:0]  out_sel_q;

    assign load = !out_valid_q || out_ready;
    assign req  = in_valid & lock_mask;

    arb_rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req       (req),
        .ptr       (ptr_q),
        .mode      (ARB_MODE == ARB_FIXED),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    // in_ready is combinational from out_ready; held low while in reset.
    assign in_ready  = (rst_n && load) ? grant : '0;
    assign xfer      = rst_n && load && any_req;
    assign beat_last = (PKT_MODE != 0) && sel_last;

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            sel_data = sel_data | (in_data[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}});
            sel_last = sel_last | (in_last[i] & grant[i]);
        end
    end

    // Lock FSM: state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_q    <= UNLOCKED;
            lock_ch_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    // Lock FSM: next state.
    always_comb begin
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        case (lock_q)
            UNLOCKED: begin
                if ((PKT_MODE != 0) && xfer && !sel_last) begin
                    lock_d    = LOCKED;
                    lock_ch_d = grant_idx;
                end
            end
            LOCKED: begin
                if (xfer && sel_last) begin
                    lock_d = UNLOCKED;
                end
            end
            default: lock_d = UNLOCKED;
        endcase
    end

    // Lock FSM: outputs. A held lock masks every request except the owner's.
    always_comb begin
        lock_mask = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            lock_mask[i] = (lock_q == UNLOCKED) || (IDX_W'(i) == lock_ch_q);
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer && !(lock_q == LOCKED && !beat_last)) begin
            ptr_d = (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (load) begin
                out_valid_q <= xfer;
                if (xfer) begin
                    out_data_q <= sel_data;
                    out_last_q <= beat_last;
                    out_sel_q  <= grant_idx;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Bench for stream_arb_mux: four configurations share one stimulus and one queue-free reference model.
module tb_stream_arb_mux;
    import arb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [3:0]   in_valid, in_last;
    logic [127:0] in_data;
    logic         out_ready;

    logic [3:0]  rdy_rr, rdy_fx, rdy_pk;
    logic [2:0]  rdy_n3;
    logic        ov_rr, ov_fx, ov_pk, ov_n3;
    logic        ol_rr, ol_fx, ol_pk, ol_n3;
    logic [31:0] od_rr, od_fx, od_pk, od_n3;
    logic [1:0]  os_rr, os_fx, os_pk, os_n3;

    stream_arb_mux #(.DATA_W(32), .NUM_CH(4), .ARB_MODE(ARB_RR), .PKT_MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_rr), .in_data(in_data),
        .in_last(in_last), .out_valid(ov_rr), .out_ready(out_ready), .out_data(od_rr),
        .out_last(ol_rr), .out_sel(os_rr));
    stream_arb_mux #(.DATA_W(32), .NUM_CH(4), .ARB_MODE(ARB_FIXED), .PKT_MODE(0)) u_fx (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_fx), .in_data(in_data),
        .in_last(in_last), .out_valid(ov_fx), .out_ready(out_ready), .out_data(od_fx),
        .out_last(ol_fx), .out_sel(os_fx));
    stream_arb_mux #(.DATA_W(32), .NUM_CH(4), .ARB_MODE(ARB_RR), .PKT_MODE(1)) u_pk (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_pk), .in_data(in_data),
        .in_last(in_last), .out_valid(ov_pk), .out_ready(out_ready), .out_data(od_pk),
        .out_last(ol_pk), .out_sel(os_pk));
    stream_arb_mux #(.DATA_W(32), .NUM_CH(3), .ARB_MODE(ARB_RR), .PKT_MODE(0)) u_n3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2:0]), .in_ready(rdy_n3),
        .in_data(in_data[95:0]), .in_last(in_last[2:0]), .out_valid(ov_n3),
        .out_ready(out_ready), .out_data(od_n3), .out_last(ol_n3), .out_sel(os_n3));

    // Reference model: per-configuration state, grant found by scanning channels in RR order.
    int          m_n  [4] = '{4, 4, 4, 3};
    bit          m_fx [4] = '{0, 1, 0, 0};
    bit          m_pk [4] = '{0, 0, 1, 0};
    int          m_ptr[4];
    bit          m_lock[4];
    int          m_lch[4];
    bit          m_ov [4];
    logic [31:0] m_od [4];
    bit          m_ol [4];
    int          m_os [4];
    int          g    [4];

    int total = 0;
    int bad   = 0;

    function automatic int model_grant(int d);
        logic [3:0] v;
        int start;
        v = in_valid;
        if (m_n[d] == 3) v[3] = 1'b0;
        if (!rst_n) return -1;
        if (m_ov[d] && !out_ready) return -1;
        if (m_lock[d]) return v[m_lch[d]] ? m_lch[d] : -1;
        start = m_fx[d] ? 0 : m_ptr[d];
        for (int k = 0; k < m_n[d]; k++) begin
            if (v[(start + k) % m_n[d]]) return (start + k) % m_n[d];
        end
        return -1;
    endfunction

    task automatic model_edge(input int d, input int gg);
        bit last;
        if (!rst_n) begin
            m_ptr[d] = 0; m_lock[d] = 0; m_lch[d] = 0;
            m_ov[d] = 0; m_od[d] = '0; m_ol[d] = 0; m_os[d] = 0;
            return;
        end
        if (m_ov[d] && !out_ready) return;
        m_ov[d] = (gg >= 0);
        if (gg < 0) return;
        last = m_pk[d] && in_last[gg];
        m_od[d] = in_data[gg*32 +: 32];
        m_ol[d] = last;
        m_os[d] = gg;
        if (!(m_lock[d] && !last)) m_ptr[d] = (gg + 1) % m_n[d];
        if (m_pk[d]) begin
            if (!m_lock[d] && !last) begin
                m_lock[d] = 1; m_lch[d] = gg;
            end else if (m_lock[d] && last) begin
                m_lock[d] = 0;
            end
        end
    endtask

    function automatic logic [3:0] act_rdy(int d);
        case (d)
            0:       return rdy_rr;
            1:       return rdy_fx;
            2:       return rdy_pk;
            default: return {1'b0, rdy_n3};
        endcase
    endfunction

    function automatic logic [35:0] act_out(int d);
        case (d)
            0:       return {ov_rr, ol_rr, os_rr, od_rr};
            1:       return {ov_fx, ol_fx, os_fx, od_fx};
            2:       return {ov_pk, ol_pk, os_pk, od_pk};
            default: return {ov_n3, ol_n3, os_n3, od_n3};
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called at the falling edge after inputs are driven; returns at the next falling edge.
    task automatic cycle();
        logic [3:0]  er;
        logic [1:0]  es;
        #1;
        for (int d = 0; d < 4; d++) begin
            g[d] = model_grant(d);
            er = '0;
            if (g[d] >= 0) er[g[d]] = 1'b1;
            chk($sformatf("model_rdy%0d", d), 64'(act_rdy(d)), 64'(er));
        end
        @(posedge clk);
        for (int d = 0; d < 4; d++) model_edge(d, g[d]);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            es = m_os[d][1:0];
            chk($sformatf("model_out%0d", d), 64'(act_out(d)), 64'({m_ov[d], m_ol[d], es, m_od[d]}));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 4'hF; in_last = 4'h0; out_ready = 1'b1;
        in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        repeat (2) begin
            #1;
            chk("rst_ready", 64'({rdy_rr, rdy_fx, rdy_pk, rdy_n3}), 64'h0);
            cycle();
            for (int d = 0; d < 4; d++) chk("rst_out", 64'(act_out(d)), 64'h0);
        end
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] v;
        logic [3:0] rdy_rr;
        int         sel_rr;
        int         sel_fx;
        int         sel_n3;   // -1: no beat expected
    } vec_t;

    initial begin
        vec_t        tbl[8];
        logic [1:0]  s;
        logic [31:0] dv;

        tbl[0] = '{4'b1111, 4'b0001, 0, 0, 0};
        tbl[1] = '{4'b1111, 4'b0010, 1, 0, 1};
        tbl[2] = '{4'b1111, 4'b0100, 2, 0, 2};
        tbl[3] = '{4'b1111, 4'b1000, 3, 0, 0};
        tbl[4] = '{4'b1111, 4'b0001, 0, 0, 1};
        tbl[5] = '{4'b1010, 4'b0010, 1, 1, 1};
        tbl[6] = '{4'b1010, 4'b1000, 3, 1, 1};
        tbl[7] = '{4'b1000, 4'b1000, 3, 3, -1};

        @(negedge clk);
        do_reset();

        // RR fairness, fixed priority, 3-channel wrap.
        for (int i = 0; i < 8; i++) begin
            in_valid = tbl[i].v; in_last = 4'hF; out_ready = 1'b1;
            #1;
            chk("tbl_ready_rr", 64'(rdy_rr), 64'(tbl[i].rdy_rr));
            cycle();
            s = tbl[i].sel_rr[1:0]; dv = 32'hA0 + 32'(tbl[i].sel_rr);
            chk("tbl_rr", 64'({ov_rr, os_rr, od_rr}), 64'({1'b1, s, dv}));
            s = tbl[i].sel_fx[1:0]; dv = 32'hA0 + 32'(tbl[i].sel_fx);
            chk("tbl_fx", 64'({ov_fx, os_fx, od_fx}), 64'({1'b1, s, dv}));
            if (tbl[i].sel_n3 < 0) begin
                chk("tbl_n3_idle", 64'(ov_n3), 64'h0);
            end else begin
                s = tbl[i].sel_n3[1:0]; dv = 32'hA0 + 32'(tbl[i].sel_n3);
                chk("tbl_n3", 64'({ov_n3, os_n3, od_n3}), 64'({1'b1, s, dv}));
            end
        end

        // Backpressure: hold beat 0xA2 for three stalled cycles.
        do_reset();
        in_valid = 4'hF;
        repeat (3) cycle();
        chk("bp_pre", 64'({ov_rr, od_rr}), 64'({1'b1, 32'hA2}));
        out_ready = 1'b0;
        repeat (3) begin
            #1;
            chk("bp_ready", 64'(rdy_rr), 64'h0);
            cycle();
            chk("bp_hold", 64'({ov_rr, os_rr, od_rr}), 64'({1'b1, 2'd2, 32'hA2}));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_resume_ready", 64'(rdy_rr), 64'h8);
        cycle();
        chk("bp_resume", 64'({ov_rr, os_rr, od_rr}), 64'({1'b1, 2'd3, 32'hA3}));

        // Packet lock on ch2 with a mid-packet gap while ch0 requests.
        do_reset();
        in_valid = 4'b0100; in_last = 4'b0000;
        #1; chk("pk_b1_ready", 64'(rdy_pk), 64'h4);
        cycle();
        chk("pk_b1", 64'({ov_pk, ol_pk, os_pk}), 64'({1'b1, 1'b0, 2'd2}));
        in_valid = 4'b0101;
        #1; chk("pk_b2_ready", 64'(rdy_pk), 64'h4);
        cycle();
        chk("pk_b2", 64'({ov_pk, ol_pk, os_pk}), 64'({1'b1, 1'b0, 2'd2}));
        in_valid = 4'b0001;
        #1; chk("pk_gap_ready", 64'(rdy_pk), 64'h0);
        cycle();
        chk("pk_gap", 64'(ov_pk), 64'h0);
        in_valid = 4'b0101; in_last = 4'b0100;
        #1; chk("pk_b3_ready", 64'(rdy_pk), 64'h4);
        cycle();
        chk("pk_b3", 64'({ov_pk, ol_pk, os_pk}), 64'({1'b1, 1'b1, 2'd2}));
        in_valid = 4'b1001; in_last = 4'b0000;
        #1; chk("pk_next_ready", 64'(rdy_pk), 64'h8);
        cycle();
        chk("pk_next", 64'({ov_pk, os_pk}), 64'({1'b1, 2'd3}));

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 63) != 0);
            in_valid  = 4'($urandom);
            in_last   = 4'($urandom & $urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_arb_mux.md
Name: stream_arb_mux

Overview:
Parametrised N-way, W-bit multiplexer with a valid/ready handshake on every input and on the output. It arbitrates among requesting channels and registers the selected beat in a single output stage. Arbitration is round-robin or fixed-priority, with an optional packet lock that holds the grant until a last-beat marker. It replaces the fixed 2-/4-way 32-bit muxes wherever multiple masters feed one datapath, such as the memory and writeback buses.

Parameters:
DATA_W, 32, width of each data channel
NUM_CH, 4, number of input channels (>=1, need not be a power of 2)
ARB_MODE, ARB_RR, ARB_RR = round-robin, ARB_FIXED = lowest index wins
PKT_MODE, 0, 1 = grant held from first beat until a beat with in_last=1 transfers

Ports:
clk  in  1  single clock
rst_n  in  1  reset; synchronous, active-low
in_valid  in  NUM_CH  per-channel request
in_ready  out  NUM_CH  per-channel accept
in_data  in  NUM_CH*DATA_W  packed channel data; channel i occupies [i*DATA_W +: DATA_W]
in_last  in  NUM_CH  per-channel end-of-packet; ignored when PKT_MODE=0
out_valid  out  1  output beat valid
out_ready  in  1  downstream accept
out_data  out  DATA_W  registered selected data
out_last  out  1  registered in_last of the selected channel (0 when PKT_MODE=0)
out_sel  out  $clog2(NUM_CH) (min 1)  index of the channel that produced out_data

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. All state updates occur on the rising edge of clk.
- Reset (rst_n=0 at a clock edge):
  - out_valid=0, out_data=0, out_last=0, out_sel=0.
  - RR pointer ptr=0; lock state = UNLOCKED.
  - A beat held in the output register is discarded.
- Load condition: load = !out_valid || out_ready.
- Handshake rules:
  - in_ready[i] = load && grant[i]. This is combinational from out_ready; the path is documented, not registered.
  - At most one in_ready bit is high in any cycle.
  - A transfer on channel i happens when in_valid[i] && in_ready[i].
- Grant selection (combinational, only when load=1):
  - ARB_FIXED: the lowest i with in_valid[i]=1.
  - ARB_RR: the first i with in_valid[i]=1, searching ptr, ptr+1, …, NUM_CH-1, 0, …, ptr-1.
  - No requester: grant=0, in_ready all 0.
- Lock FSM (PKT_MODE=1 only):
  - UNLOCKED -> LOCKED(ch) on a transfer from ch with in_last=0.
  - LOCKED(ch) -> UNLOCKED on a transfer from ch with in_last=1.
  - While LOCKED, grant is restricted to ch. Other channels get in_ready=0 even when ch is idle (in_valid[ch]=0).
  - PKT_MODE=0: the FSM stays UNLOCKED permanently.
- Pointer update (RR): on each transfer from channel i, ptr <= (i==NUM_CH-1) ? 0 : i+1. The wrap is explicit so non-power-of-2 NUM_CH works. In LOCKED state, ptr updates only on the terminating last beat.
- Output register:
  - load && transfer: out_valid<=1 and out_data/out_last/out_sel are captured from the granted channel.
  - load && no transfer: out_valid<=0; data regs hold their previous values (don't-care).
  - !load (stall: out_valid && !out_ready): all outputs hold stable and all in_ready are 0.
- Latency and throughput: 1 cycle from input transfer to out_valid. With out_ready held at 1, throughput is one beat per cycle with no bubbles.
- NUM_CH=1: degenerates to a registered pipe stage; out_sel is always 0.
- Simultaneous events: when out_ready=1 and a new grant occur in the same cycle, the old beat leaves and the new beat loads in that cycle.

Decomposition:
- Package arb_pkg:
  - ARB_RR/ARB_FIXED localparams.
  - Lock-state enum (UNLOCKED, LOCKED).
  - CH_IDX_W helper function (clog2 with a minimum of 1).
- One sub-module, arb_rr_pick (combinational):
  - Inputs: req[NUM_CH], ptr, mode.
  - Outputs: one-hot grant, binary grant index, any_req.
  - Implemented as a double-width masked priority encode.
- Top-level stream_arb_mux holds the lock FSM, the ptr register, the output register, and the data mux (AND-OR over the one-hot grant).

Test Plan:
1. Reset behaviour: assert rst_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0. First grant after release goes to ch0.
2. RR fairness: NUM_CH=4, in_valid=4'b1111, out_ready=1, in_data[i]=32'hA0+i -> out_sel sequence 0,1,2,3,0. out_data goes 0xA0..0xA3 then 0xA0, one beat per cycle.
3. Fixed priority: ARB_FIXED, in_valid=4'b1010 -> only ch1 is granted (out_data=0xA1 every cycle). Ch3 is granted only after in_valid[1] drops.
4. Backpressure: out_valid=1 with out_data=0xA2 and out_ready=0 for 3 cycles -> out_data stays 0xA2 and in_ready=0 throughout. On out_ready=1, the next grant is ch3.
5. Packet lock: PKT_MODE=1, ch2 sends 3 beats (in_last on beat 3) while ch0 requests; ch2 deasserts valid for 1 cycle mid-packet -> ch0 is not granted until ch2's last beat transfers. Ch3 (next in RR order) is then granted if requesting, else ch0.
6. Non-power-of-2 wrap: NUM_CH=3, all requesting -> out_sel sequence 0,1,2,0,1. ptr never reaches 3.
